// File: rtl/irq_source_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : irq_source_ctrl_if                                               |
// | Brief   : CPU-side request/ack/config bundle for irq_source_ctrl.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface irq_source_ctrl_if #(
  parameter int N_SRC       = 8,
  parameter int TIMER_WIDTH = 32
);
  localparam int NUM_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]       raw_irq;
  logic                   mask_we;
  logic [N_SRC-1:0]       mask_wdata;
  logic                   timer_period_we;
  logic [TIMER_WIDTH-1:0] timer_period_wdata;
  logic                   irq_ack;
  logic [NUM_W-1:0]       irq_ack_num;
  logic [N_SRC-1:0]       hardware_interrupt;
  logic [N_SRC-1:0]       irq_pending;
  logic [N_SRC-1:0]       irq_mask;

  modport master (
    output raw_irq, mask_we, mask_wdata, timer_period_we, timer_period_wdata,
           irq_ack, irq_ack_num,
    input  hardware_interrupt, irq_pending, irq_mask
  );

  modport slave (
    input  raw_irq, mask_we, mask_wdata, timer_period_we, timer_period_wdata,
           irq_ack, irq_ack_num,
    output hardware_interrupt, irq_pending, irq_mask
  );
endinterface
`default_nettype wire

// File: rtl/irq_source_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : irq_source_ctrl                                                  |
// | Brief   : Sync/edge-detect IRQ lines plus interval timer; presents one     |
// |           masked pending request one-hot until acknowledged by number.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module irq_source_ctrl #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_WIDTH = 32,
  parameter int TIMER_SRC   = 7
) (
  input  logic             clk,
  input  logic             clr_n,
  irq_source_ctrl_if.slave bus
);
  localparam int NUM_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ASSERT = 2'd1;
  localparam logic [1:0] c_GAP    = 2'd2;

  localparam logic [N_SRC-1:0]       c_ONE   = N_SRC'(1);
  localparam logic [TIMER_WIDTH-1:0] c_T_ONE = TIMER_WIDTH'(1);

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0]                  dly_q;
  logic [N_SRC-1:0]                  pending_q, pending_d;
  logic [N_SRC-1:0]                  mask_q;
  logic [N_SRC-1:0]                  hw_q, hw_d;
  logic [TIMER_WIDTH-1:0]            period_q, period_d;
  logic [TIMER_WIDTH-1:0]            count_q, count_d;
  logic [1:0]                        state_q, state_d;
  logic [NUM_W-1:0]                  cur_q, cur_d;

  logic [N_SRC-1:0] w_ev;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_avail;
  logic [NUM_W-1:0] w_sel;
  logic             w_tick;
  logic             w_ack_hit;

  assign w_ev      = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign w_tick    = (period_q != '0) && (count_q == c_T_ONE);
  assign w_ack_hit = (state_q == c_ASSERT) && bus.irq_ack && (bus.irq_ack_num == cur_q);
  assign w_clr     = w_ack_hit ? (c_ONE << cur_q) : '0;
  assign w_avail   = pending_q & mask_q;

  // A new event in the ack cycle keeps the bit set so it is not lost.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    if (gi == TIMER_SRC) begin : g_timer
      assign pending_d[gi] = (pending_q[gi] & ~w_clr[gi]) | w_ev[gi] | w_tick;
    end else begin : g_plain
      assign pending_d[gi] = (pending_q[gi] & ~w_clr[gi]) | w_ev[gi];
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_avail[i]) w_sel = NUM_W'(i);
    end
  end

  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    if (bus.timer_period_we) begin
      period_d = bus.timer_period_wdata;
      count_d  = bus.timer_period_wdata;
    end else if (period_q != '0) begin
      count_d = w_tick ? period_q : (count_q - c_T_ONE);
    end
  end

  // Selection only happens from IDLE, so an in-service request is never preempted.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hw_d    = hw_q;
    case (state_q)
      c_IDLE: begin
        if (|w_avail) begin
          cur_d   = w_sel;
          hw_d    = c_ONE << w_sel;
          state_d = c_ASSERT;
        end
      end
      c_ASSERT: begin
        if (w_ack_hit) begin
          hw_d    = '0;
          state_d = c_GAP;
        end
      end
      c_GAP: begin
        state_d = c_IDLE;
      end
      default: begin
        hw_d    = '0;
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q    <= '0;
      dly_q     <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      hw_q      <= '0;
      period_q  <= '0;
      count_q   <= '0;
      state_q   <= c_IDLE;
      cur_q     <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.raw_irq};
      dly_q     <= sync_q[SYNC_STAGES-1];
      pending_q <= pending_d;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      hw_q      <= hw_d;
      period_q  <= period_d;
      count_q   <= count_d;
      state_q   <= state_d;
      cur_q     <= cur_d;
    end
  end

  assign bus.hardware_interrupt = hw_q;
  assign bus.irq_pending        = pending_q;
  assign bus.irq_mask           = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_source_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_irq_source_ctrl                                               |
// | Brief   : Scenario tasks with a queue of expected one-hot requests.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_irq_source_ctrl;
  localparam int N_SRC = 8;
  localparam int TW    = 32;

  logic        clk   = 1'b0;
  logic        clr_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int unsigned cycles = 0;
  logic [7:0]  exp_q[$];

  irq_source_ctrl_if #(.N_SRC(N_SRC), .TIMER_WIDTH(TW)) bus ();

  irq_source_ctrl #(
    .N_SRC(N_SRC), .SYNC_STAGES(2), .TIMER_WIDTH(TW), .TIMER_SRC(7)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycles <= cycles + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_hw(input int budget, output logic [7:0] got, output bit timed_out);
    int n = 0;
    timed_out = 1'b1;
    got = '0;
    while (n < budget) begin
      if (bus.hardware_interrupt != 8'h00) begin
        got = bus.hardware_interrupt;
        timed_out = 1'b0;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic do_ack(input logic [2:0] num);
    bus.irq_ack = 1'b1;
    bus.irq_ack_num = num;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    bus.raw_irq = '0; bus.mask_we = 0; bus.mask_wdata = '0;
    bus.timer_period_we = 0; bus.timer_period_wdata = '0;
    bus.irq_ack = 0; bus.irq_ack_num = '0;
    tick(3);
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL reset_hw: got %h want 00", bus.hardware_interrupt); end
    checks++; if (bus.irq_pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", bus.irq_pending); end
    checks++; if (bus.irq_mask !== 8'hFF) begin errors++; $display("FAIL reset_mask: got %h want FF", bus.irq_mask); end
    @(negedge clk) clr_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] want;
    bus.raw_irq[3] = 1'b1;
    exp_q.push_back(8'h08);
    tick(3);
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL single_early: got %h want 00", bus.hardware_interrupt); end
    checks++; if (bus.irq_pending !== 8'h08) begin errors++; $display("FAIL single_pending: got %h want 08", bus.irq_pending); end
    tick();
    want = exp_q.pop_front();
    checks++; if (bus.hardware_interrupt !== want) begin errors++; $display("FAIL single_out: got %h want %h", bus.hardware_interrupt, want); end
    tick(3);
    checks++; if (bus.hardware_interrupt !== want) begin errors++; $display("FAIL single_hold: got %h want %h", bus.hardware_interrupt, want); end
    do_ack(3'd3);
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL single_ack_out: got %h want 00", bus.hardware_interrupt); end
    checks++; if (bus.irq_pending[3] !== 1'b0) begin errors++; $display("FAIL single_ack_pend: got %b want 0", bus.irq_pending[3]); end
    tick(6);
    checks++; if (bus.irq_pending !== 8'h00) begin errors++; $display("FAIL single_level_once: got %h want 00", bus.irq_pending); end
    bus.raw_irq[3] = 1'b0;
    tick(4);
  endtask

  task automatic test_priority();
    logic [7:0] want, got;
    bit to;
    bus.raw_irq[2] = 1'b1;
    bus.raw_irq[5] = 1'b1;
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h04);
    wait_hw(10, got, to);
    want = exp_q.pop_front();
    checks++; if (to || got !== want) begin errors++; $display("FAIL prio_first: got %h timeout %0d want %h", got, to, want); end
    do_ack(3'd5);
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL prio_gap: got %h want 00", bus.hardware_interrupt); end
    tick();
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL prio_idle: got %h want 00", bus.hardware_interrupt); end
    tick();
    want = exp_q.pop_front();
    checks++; if (bus.hardware_interrupt !== want) begin errors++; $display("FAIL prio_second: got %h want %h", bus.hardware_interrupt, want); end
    do_ack(3'd2);
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL prio_done: got %h want 00", bus.hardware_interrupt); end
    bus.raw_irq[2] = 1'b0;
    bus.raw_irq[5] = 1'b0;
    tick(4);
  endtask

  task automatic test_mask();
    logic [7:0] want;
    bus.mask_we = 1'b1; bus.mask_wdata = 8'hF7;
    tick();
    bus.mask_we = 1'b0;
    checks++; if (bus.irq_mask !== 8'hF7) begin errors++; $display("FAIL mask_load: got %h want F7", bus.irq_mask); end
    bus.raw_irq[3] = 1'b1;
    tick(6);
    checks++; if (bus.irq_pending !== 8'h08) begin errors++; $display("FAIL mask_pending: got %h want 08", bus.irq_pending); end
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL mask_blocked: got %h want 00", bus.hardware_interrupt); end
    exp_q.push_back(8'h08);
    bus.mask_we = 1'b1; bus.mask_wdata = 8'hFF;
    tick();
    bus.mask_we = 1'b0;
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL mask_write_edge: got %h want 00", bus.hardware_interrupt); end
    tick();
    want = exp_q.pop_front();
    checks++; if (bus.hardware_interrupt !== want) begin errors++; $display("FAIL mask_release: got %h want %h", bus.hardware_interrupt, want); end
    do_ack(3'd3);
    bus.raw_irq[3] = 1'b0;
    tick(4);
  endtask

  task automatic test_timer();
    logic [7:0] want, got;
    bit to;
    int unsigned c_w;
    int n;
    bus.timer_period_we = 1'b1; bus.timer_period_wdata = 32'd10;
    tick();
    bus.timer_period_we = 1'b0;
    c_w = cycles;
    n = 0;
    while (bus.irq_pending[7] !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (cycles - c_w != 10) begin errors++; $display("FAIL timer_first: tick after %0d edges want 10", cycles - c_w); end
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL timer_out_early: got %h want 00", bus.hardware_interrupt); end
    exp_q.push_back(8'h80);
    tick();
    want = exp_q.pop_front();
    checks++; if (bus.hardware_interrupt !== want) begin errors++; $display("FAIL timer_out: got %h want %h", bus.hardware_interrupt, want); end
    do_ack(3'd7);
    checks++; if (bus.irq_pending[7] !== 1'b0) begin errors++; $display("FAIL timer_ack: pending %b want 0", bus.irq_pending[7]); end
    n = 0;
    while (bus.irq_pending[7] !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (cycles - c_w != 20) begin errors++; $display("FAIL timer_second: tick after %0d edges want 20", cycles - c_w); end
    exp_q.push_back(8'h80);
    wait_hw(5, got, to);
    want = exp_q.pop_front();
    checks++; if (to || got !== want) begin errors++; $display("FAIL timer_out2: got %h timeout %0d want %h", got, to, want); end
    do_ack(3'd7);
    bus.timer_period_we = 1'b1; bus.timer_period_wdata = 32'd0;
    tick();
    bus.timer_period_we = 1'b0;
    tick(35);
    checks++; if (bus.irq_pending !== 8'h00 || bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL timer_off: pending %h out %h want 00 00", bus.irq_pending, bus.hardware_interrupt); end
  endtask

  task automatic test_wrong_ack();
    logic [7:0] want, got;
    bit to;
    do_ack(3'd4);
    checks++; if (bus.hardware_interrupt !== 8'h00 || bus.irq_pending !== 8'h00) begin errors++; $display("FAIL idle_ack: out %h pending %h want 00 00", bus.hardware_interrupt, bus.irq_pending); end
    bus.raw_irq[4] = 1'b1;
    exp_q.push_back(8'h10);
    wait_hw(10, got, to);
    want = exp_q.pop_front();
    checks++; if (to || got !== want) begin errors++; $display("FAIL wack_first: got %h timeout %0d want %h", got, to, want); end
    do_ack(3'd1);
    tick(2);
    checks++; if (bus.hardware_interrupt !== 8'h10) begin errors++; $display("FAIL wack_ignored: got %h want 10", bus.hardware_interrupt); end
    bus.raw_irq[4] = 1'b0;
    tick(4);
    bus.raw_irq[4] = 1'b1;
    tick(2);
    do_ack(3'd4);
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL wack_ack_out: got %h want 00", bus.hardware_interrupt); end
    checks++; if (bus.irq_pending[4] !== 1'b1) begin errors++; $display("FAIL wack_set_wins: pending %b want 1", bus.irq_pending[4]); end
    exp_q.push_back(8'h10);
    tick();
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL wack_gap: got %h want 00", bus.hardware_interrupt); end
    tick();
    want = exp_q.pop_front();
    checks++; if (bus.hardware_interrupt !== want) begin errors++; $display("FAIL wack_repres: got %h want %h", bus.hardware_interrupt, want); end
    do_ack(3'd4);
    bus.raw_irq[4] = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_mid();
    logic [7:0] want, got;
    bit to;
    bus.mask_we = 1'b1; bus.mask_wdata = 8'h7F;
    tick();
    bus.mask_we = 1'b0;
    bus.raw_irq[6] = 1'b1;
    exp_q.push_back(8'h40);
    wait_hw(10, got, to);
    want = exp_q.pop_front();
    checks++; if (to || got !== want) begin errors++; $display("FAIL rmid_pre: got %h timeout %0d want %h", got, to, want); end
    bus.timer_period_we = 1'b1; bus.timer_period_wdata = 32'd3;
    tick();
    bus.timer_period_we = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    checks++; if (bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL rmid_out: got %h want 00", bus.hardware_interrupt); end
    checks++; if (bus.irq_pending !== 8'h00) begin errors++; $display("FAIL rmid_pending: got %h want 00", bus.irq_pending); end
    checks++; if (bus.irq_mask !== 8'hFF) begin errors++; $display("FAIL rmid_mask: got %h want FF", bus.irq_mask); end
    bus.raw_irq[6] = 1'b0;
    tick(2);
    @(negedge clk) clr_n = 1'b1;
    tick(20);
    checks++; if (bus.irq_pending !== 8'h00 || bus.hardware_interrupt !== 8'h00) begin errors++; $display("FAIL rmid_no_tick: pending %h out %h want 00 00", bus.irq_pending, bus.hardware_interrupt); end
    checks++; if (bus.irq_mask !== 8'hFF) begin errors++; $display("FAIL rmid_mask_after: got %h want FF", bus.irq_mask); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_timer();
    test_wrong_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
